// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the RV32I load/store controller: funct3 encodings,
// FSM state type and the access legality check.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        MERGE   = 3'd3,
        WRITE   = 3'd4,
        RESP    = 3'd5
    } state_t;

    // Unsigned variants exist only for loads; H/W need natural alignment.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            F3_BU:   ok = ~we;
            F3_HU:   ok = ~we & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, and merges sub-word
// store data into the word read back from memory.
module lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (lane)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_BU:   load_data = {24'd0, sel_byte};
            F3_HU:   load_data = {16'd0, sel_half};
            default: load_data = rdata;
        endcase
    end

    // Only the addressed lane is replaced; the other bytes keep the value just read.
    always_comb begin
        store_data = rdata;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0:    store_data[7:0]   = wdata[7:0];
                    2'd1:    store_data[15:8]  = wdata[7:0];
                    2'd2:    store_data[23:16] = wdata[7:0];
                    default: store_data[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (lane[1]) store_data[31:16] = wdata[15:0];
                else         store_data[15:0]  = wdata[15:0];
            end
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store controller between the RV32I execute stage and a word-wide
// data memory with 1-cycle registered read and full-word writes.
module dmem_lsu_ctrl
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    state_t            state;
    logic              op_we;
    logic [2:0]        op_funct3;
    logic [ADDR_W-3:0] op_word;
    logic [1:0]        op_lane;
    logic [XLEN-1:0]   op_wdata;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   store_data;

    lsu_lane_align u_align (
        .rdata      (mem_rdata),
        .wdata      (op_wdata),
        .lane       (op_lane),
        .funct3     (op_funct3),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_funct3 <= 3'd0;
            op_word   <= '0;
            op_lane   <= 2'd0;
            op_wdata  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we     <= req_we;
                        op_funct3 <= req_funct3;
                        op_word   <= req_addr[ADDR_W-1:2];
                        op_lane   <= req_addr[1:0];
                        op_wdata  <= req_wdata;
                        rdata_q   <= '0;
                        if (!is_legal(req_we, req_funct3, req_addr[1:0])) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            err_q <= 1'b0;
                            state <= (req_we && req_funct3 == F3_W) ? WRITE : READ;
                        end
                    end
                end
                READ:    state <= op_we ? MERGE : CAPTURE;
                CAPTURE: begin
                    rdata_q <= load_data;
                    state   <= RESP;
                end
                MERGE:   state <= RESP;
                WRITE:   state <= RESP;
                RESP:    if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes are masked by rst directly so a reset mid-RMW never commits.
    always_comb begin
        mem_en    = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                READ: begin
                    mem_en   = 1'b1;
                    mem_addr = {op_word, 2'b00};
                end
                MERGE: begin
                    mem_en    = 1'b1;
                    mem_rw    = 1'b1;
                    mem_addr  = {op_word, 2'b00};
                    mem_wdata = store_data;
                end
                WRITE: begin
                    mem_en    = 1'b1;
                    mem_rw    = 1'b1;
                    mem_addr  = {op_word, 2'b00};
                    mem_wdata = op_wdata;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = (state == RESP) ? rdata_q : '0;
    assign resp_err   = (state == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Scoreboard bench for dmem_lsu_ctrl with a behavioural 1-cycle-read data memory.
module tb_dmem_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [9:0]  mem_addr;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          k;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:255];
    logic [9:0]  last_waddr = '0;
    int          en_cnt = 0;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    dmem_lsu_ctrl #(.ADDR_W(10), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_en     (mem_en),
        .mem_rw     (mem_rw),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_rw) begin
                mem[mem_addr[9:2]] <= mem_wdata;
                last_waddr         <= mem_addr;
            end else begin
                mem_rdata <= mem[mem_addr[9:2]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        checkOutput({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        checkOutput({tag, "_mem_rw"}, 32'(mem_rw), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // One full transaction: request, scoreboard push, optional response stall, handshake.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                 input logic exp_err, input int exp_k, input int stall);
        int   acc;
        int   waited;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("req_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.k     = exp_k;
        sb_q.push_back(e);
        @(negedge clk);
        acc = cyc;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = 10'($urandom);
        req_wdata  = $urandom;
        waited = 0;
        while (!resp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!resp_valid) begin
            checkOutput("resp_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        checkOutput("latency", 32'(cyc - acc + 1), 32'(e.k));
        checkOutput("rdata", resp_rdata, e.rdata);
        checkOutput("err", 32'(resp_err), 32'(e.err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold_rdata", resp_rdata, e.rdata);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("done_valid", 32'(resp_valid), 32'd0);
        checkOutput("done_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int en_before;
        int waited;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready_low", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkResetOutputs("reset");

        applyStimulus(1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0);
        checkOutput("sw_waddr", 32'(last_waddr), 32'h010);
        applyStimulus(1'b0, 3'b010, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);

        applyStimulus(1'b1, 3'b010, 10'h020, 32'h11223344, 32'h0, 1'b0, 2, 0);
        applyStimulus(1'b1, 3'b000, 10'h022, 32'h000000AA, 32'h0, 1'b0, 3, 0);
        applyStimulus(1'b0, 3'b010, 10'h020, 32'h0, 32'h11AA3344, 1'b0, 3, 0);
        applyStimulus(1'b1, 3'b001, 10'h020, 32'h00005566, 32'h0, 1'b0, 3, 0);
        applyStimulus(1'b0, 3'b010, 10'h020, 32'h0, 32'h11AA5566, 1'b0, 3, 0);

        applyStimulus(1'b1, 3'b010, 10'h030, 32'h8001FF7F, 32'h0, 1'b0, 2, 0);
        applyStimulus(1'b0, 3'b000, 10'h030, 32'h0, 32'h0000007F, 1'b0, 3, 0);
        applyStimulus(1'b0, 3'b000, 10'h031, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 0);
        applyStimulus(1'b0, 3'b100, 10'h031, 32'h0, 32'h000000FF, 1'b0, 3, 0);
        applyStimulus(1'b0, 3'b000, 10'h033, 32'h0, 32'hFFFFFF80, 1'b0, 3, 0);
        applyStimulus(1'b0, 3'b001, 10'h032, 32'h0, 32'hFFFF8001, 1'b0, 3, 0);
        applyStimulus(1'b0, 3'b101, 10'h032, 32'h0, 32'h00008001, 1'b0, 3, 0);
        applyStimulus(1'b0, 3'b001, 10'h030, 32'h0, 32'hFFFFFF7F, 1'b0, 3, 0);

        @(negedge clk);
        en_before = en_cnt;
        applyStimulus(1'b0, 3'b010, 10'h013, 32'h0, 32'h0, 1'b1, 1, 0);
        applyStimulus(1'b1, 3'b001, 10'h021, 32'h1234, 32'h0, 1'b1, 1, 0);
        applyStimulus(1'b1, 3'b100, 10'h020, 32'h12, 32'h0, 1'b1, 1, 0);
        applyStimulus(1'b0, 3'b011, 10'h020, 32'h0, 32'h0, 1'b1, 1, 0);
        checkOutput("err_no_mem_access", 32'(en_cnt - en_before), 32'd0);

        applyStimulus(1'b0, 3'b010, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 5);
        applyStimulus(1'b0, 3'b010, 10'h020, 32'h0, 32'h11AA5566, 1'b0, 3, 0);

        applyStimulus(1'b1, 3'b010, 10'h3FC, 32'h12345678, 32'h0, 1'b0, 2, 0);
        applyStimulus(1'b1, 3'b000, 10'h3FF, 32'h000000CC, 32'h0, 1'b0, 3, 0);
        checkOutput("sb_wrap_waddr", 32'(last_waddr), 32'h3FC);
        applyStimulus(1'b0, 3'b010, 10'h3FC, 32'h0, 32'hCC345678, 1'b0, 3, 0);

        // Reset lands in the MERGE cycle of an SB; the word must stay untouched.
        applyStimulus(1'b1, 3'b010, 10'h040, 32'h01020304, 32'h0, 1'b0, 2, 0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 10'h041;
        req_wdata  = 32'h000000EE;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rmw_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rmw_merge_write", 32'({mem_en, mem_rw}), 32'h3);
        rst = 1'b1;
        #1;
        checkOutput("rst_forces_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetOutputs("midrst");
        applyStimulus(1'b0, 3'b010, 10'h040, 32'h0, 32'h01020304, 1'b0, 3, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
Load/store controller between the RV32I execute stage and the word-wide data memory (10-bit byte address, 32-bit little-endian word, 1-cycle registered read, full-word write only).
- Accepts one load/store request at a time over a valid/ready handshake.
- Implements LB/LH/LW/LBU/LHU/SB/SH/SW; sub-word stores use read-modify-write.
- Checks alignment and returns the formatted load result or an error on a response handshake.

Parameters:
ADDR_W, 10, byte address width; must match the data memory address width.
XLEN, 32, data width; fixed at 32 (RV32I).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data; low bytes used for SB/SH
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  1  misaligned access or illegal funct3
busy  out  1  state != IDLE
mem_addr  out  ADDR_W  memory address; always word-aligned ({req_addr[ADDR_W-1:2], 2'b00})
mem_en  out  1  memory enable
mem_rw  out  1  1 = write, 0 = read
mem_wdata  out  XLEN  write word
mem_rdata  in  XLEN  memory read data; valid the cycle after a read-enabled edge

Behaviour:
- Reset state: IDLE. Reset values: req_ready=1 (once rst is low), resp_valid=0, resp_rdata=0, resp_err=0, busy=0, mem_en=0, mem_rw=0, mem_addr=0, mem_wdata=0.
- Memory outputs are 0 in every state except READ, WRITE and MERGE.
- Accept: handshake when req_valid && req_ready at edge N. At that edge, latch op, funct3, addr, wdata and lane = addr[1:0].
- Error check at accept. An access is illegal if:
  - funct3 is 011, 110 or 111;
  - it is a store with funct3 100 or 101;
  - it is an H/HU access with addr[0] != 0;
  - it is a W access with addr[1:0] != 0.
  Illegal access goes to RESP with resp_err=1 and resp_rdata=0. No memory access occurs.
- States and transitions:
  - IDLE -> READ on a legal load or legal SB/SH.
  - IDLE -> WRITE on a legal SW.
  - IDLE -> RESP on an error.
  - READ: mem_en=1, mem_rw=0, aligned address. Load -> CAPTURE; SB/SH -> MERGE.
  - CAPTURE: select lane from mem_rdata; sign-extend (B/H) or zero-extend (BU/HU); register into resp_rdata -> RESP.
  - MERGE: mem_en=1, mem_rw=1. mem_wdata = mem_rdata with lane byte(s) replaced by req_wdata[7:0] or [15:0] -> RESP.
  - WRITE: mem_en=1, mem_rw=1, mem_wdata=req_wdata -> RESP.
  - RESP: resp_valid=1, outputs held stable until resp_ready. On resp_ready -> IDLE; resp_valid drops next cycle.
- Latency, with resp_valid asserted from cycle N+k:
  - loads k=3.
  - SW k=2.
  - SB/SH k=3 (one read plus one write).
  - errors k=1.
- Back-to-back throughput: minimum one request per (k+1) cycles. No request is accepted in the cycle resp_ready is taken.
- Halfword lanes: lane 0 = bytes [15:0], lane 2 = bytes [31:16].
- Wrap-around: memory accesses are always word-aligned, so an address+3 beyond 2^ADDR_W-1 never occurs. SB to 0x3FF touches only word 0x3FC.
- Reset mid-operation: state returns to IDLE the same edge and mem_en is forced to 0 combinationally while rst=1, so no partial write is committed. A pending response is discarded.
- Back-pressure: the request port is ignored outside IDLE (req_ready=0). req_* may change freely after acceptance.

Decomposition:
- Package dmem_lsu_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - state enum {IDLE, READ, CAPTURE, MERGE, WRITE, RESP};
  - a function is_legal(we, funct3, addr_lo).
- One combinational sub-module, lsu_lane_align, provides:
  - load extract/extend (rdata, lane, funct3 -> XLEN);
  - store merge (rdata, wdata, lane, funct3 -> XLEN).
- The FSM stays in dmem_lsu_ctrl.

Test Plan:
- SW addr 0x010 data 0xDEADBEEF -> mem write at 0x010 in cycle N+1, resp_valid at N+2, err=0. Then LW 0x010 -> resp_rdata 0xDEADBEEF at N+3.
- Word 0x11223344 at 0x020. SB addr 0x022 wdata 0x000000AA -> read then write 0x11AA3344. SH addr 0x020 wdata 0x5566 -> 0x11AA5566.
- Word 0x8001FF7F at 0x030:
  - LB 0x030 -> 0x0000007F.
  - LB 0x031 -> 0xFFFFFFFF.
  - LBU 0x031 -> 0x000000FF.
  - LH 0x032 -> 0xFFFF8001.
  - LHU 0x032 -> 0x00008001.
- LW 0x013, SH 0x021, store funct3=100 -> resp_err=1, rdata=0, resp at N+1, mem_en never asserted.
- resp_ready held 0 for 5 cycles after an LW -> resp_valid/resp_rdata stable, req_ready=0. Release -> IDLE next cycle, next request accepted.
- SB 0x3FF 0xCC -> mem_addr 0x3FC, only byte 3 changed. Assert rst in the MERGE cycle of an SB -> no write (memory word unchanged), all outputs at reset values next cycle.
